// File: rtl/lcd_timing_gen_if.sv
// Panel-side bundle of the LCD timing generator.
//   enable, mirror_x, mirror_y      : control from the consumer (lab/top)
//   pixel_en, de, hsync, vsync      : pixel strobe and panel sync signals
//   x, y                            : active-area coordinates
//   line_start, frame_start         : single-clk markers aligned with pixel_en
//   frame_count                     : completed-frame counter
// master = the timing generator, slave = the consumer of the timing.
interface lcd_timing_gen_if #(
    parameter int unsigned w_x     = 9,
    parameter int unsigned w_y     = 9,
    parameter int unsigned w_frame = 16
);
    logic               enable;
    logic               mirror_x;
    logic               mirror_y;
    logic               pixel_en;
    logic               de;
    logic               hsync;
    logic               vsync;
    logic [w_x-1:0]     x;
    logic [w_y-1:0]     y;
    logic               line_start;
    logic               frame_start;
    logic [w_frame-1:0] frame_count;

    modport master (
        input  enable, mirror_x, mirror_y,
        output pixel_en, de, hsync, vsync, x, y, line_start, frame_start, frame_count
    );

    modport slave (
        output enable, mirror_x, mirror_y,
        input  pixel_en, de, hsync, vsync, x, y, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/lcd_timing_gen.sv
// Parametrised LCD/RGB-panel timing generator.
// Divides clk by clk_div into pixel periods and walks an h_total x v_total raster,
// producing registered DE, HSYNC, VSYNC, coordinates, line/frame markers and a
// completed-frame counter. Mirroring requests are latched once per frame.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : lcd_timing_gen_if.master (enable/mirror in, timing outputs out)
module lcd_timing_gen #(
    parameter int unsigned clk_div  = 3,
    parameter int unsigned h_active = 480,
    parameter int unsigned h_front  = 8,
    parameter int unsigned h_sync   = 4,
    parameter int unsigned h_back   = 43,
    parameter int unsigned v_active = 272,
    parameter int unsigned v_front  = 8,
    parameter int unsigned v_sync   = 4,
    parameter int unsigned v_back   = 12,
    parameter bit          hs_pol   = 1'b0,
    parameter bit          vs_pol   = 1'b0,
    parameter int unsigned w_x      = $clog2(h_active),
    parameter int unsigned w_y      = $clog2(v_active),
    parameter int unsigned w_frame  = 16
) (
    input logic              clk,
    input logic              rst,
    lcd_timing_gen_if.master bus
);
    localparam int unsigned h_total = h_active + h_front + h_sync + h_back;
    localparam int unsigned v_total = v_active + v_front + v_sync + v_back;
    localparam int unsigned w_h     = $clog2(h_total);
    localparam int unsigned w_v     = $clog2(v_total);
    localparam int unsigned w_div   = (clk_div > 1) ? $clog2(clk_div) : 1;

    if (clk_div < 1 || h_sync < 1 || v_sync < 1 ||
        h_active > (32'd1 << w_x) || v_active > (32'd1 << w_y)) begin : g_param_check
        $error("lcd_timing_gen: illegal parameter set");
    end

    logic             running;
    logic [w_div-1:0] div;
    logic [w_h-1:0]   hcnt;
    logic [w_v-1:0]   vcnt;
    logic             mirror_x_l;
    logic             mirror_y_l;

    logic             pix_start;
    logic             frame_wrap;
    logic             frame_begin;
    logic [w_h-1:0]   h_nxt;
    logic [w_v-1:0]   v_nxt;
    logic             mx;
    logic             my;
    logic             de_nxt;
    logic             hs_act;
    logic             vs_act;
    logic [w_x-1:0]   x_nxt;
    logic [w_y-1:0]   y_nxt;

    // Raster position of the pixel that the next pixel boundary will present.
    // Leaving idle always presents (0,0) without counting a completed frame.
    always_comb begin
        pix_start  = !running || (div == w_div'(clk_div - 1));
        h_nxt      = '0;
        v_nxt      = '0;
        frame_wrap = 1'b0;
        if (running) begin
            if (hcnt == w_h'(h_total - 1)) begin
                if (vcnt == w_v'(v_total - 1)) begin
                    frame_wrap = 1'b1;
                end else begin
                    v_nxt = vcnt + w_v'(1);
                end
            end else begin
                h_nxt = hcnt + w_h'(1);
                v_nxt = vcnt;
            end
        end
        frame_begin = (h_nxt == '0) && (v_nxt == '0);
        // Mirror requests take effect on the frame's first pixel itself.
        mx     = frame_begin ? bus.mirror_x : mirror_x_l;
        my     = frame_begin ? bus.mirror_y : mirror_y_l;
        de_nxt = (32'(h_nxt) < h_active) && (32'(v_nxt) < v_active);
        hs_act = (32'(h_nxt) >= h_active + h_front) &&
                 (32'(h_nxt) <  h_active + h_front + h_sync);
        vs_act = (32'(v_nxt) >= v_active + v_front) &&
                 (32'(v_nxt) <  v_active + v_front + v_sync);
        x_nxt  = '0;
        y_nxt  = '0;
        if (de_nxt) begin
            x_nxt = mx ? w_x'(h_active - 1 - 32'(h_nxt)) : w_x'(h_nxt);
            y_nxt = my ? w_y'(v_active - 1 - 32'(v_nxt)) : w_y'(v_nxt);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running         <= 1'b0;
            div             <= '0;
            hcnt            <= '0;
            vcnt            <= '0;
            mirror_x_l      <= 1'b0;
            mirror_y_l      <= 1'b0;
            bus.pixel_en    <= 1'b0;
            bus.de          <= 1'b0;
            bus.hsync       <= ~hs_pol;
            bus.vsync       <= ~vs_pol;
            bus.x           <= '0;
            bus.y           <= '0;
            bus.line_start  <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.frame_count <= '0;
        end else if (!bus.enable) begin
            // Idle and restart; the frame counter survives an enable drop.
            running         <= 1'b0;
            div             <= '0;
            hcnt            <= '0;
            vcnt            <= '0;
            mirror_x_l      <= 1'b0;
            mirror_y_l      <= 1'b0;
            bus.pixel_en    <= 1'b0;
            bus.de          <= 1'b0;
            bus.hsync       <= ~hs_pol;
            bus.vsync       <= ~vs_pol;
            bus.x           <= '0;
            bus.y           <= '0;
            bus.line_start  <= 1'b0;
            bus.frame_start <= 1'b0;
        end else begin
            running <= 1'b1;
            if (pix_start) begin
                div             <= '0;
                hcnt            <= h_nxt;
                vcnt            <= v_nxt;
                bus.pixel_en    <= 1'b1;
                bus.de          <= de_nxt;
                bus.hsync       <= hs_act ? hs_pol : ~hs_pol;
                bus.vsync       <= vs_act ? vs_pol : ~vs_pol;
                bus.x           <= x_nxt;
                bus.y           <= y_nxt;
                bus.line_start  <= (h_nxt == '0);
                bus.frame_start <= frame_begin;
                if (frame_begin) begin
                    mirror_x_l <= bus.mirror_x;
                    mirror_y_l <= bus.mirror_y;
                end
                if (frame_wrap) begin
                    bus.frame_count <= bus.frame_count + w_frame'(1);
                end
            end else begin
                // Pixel values hold; only the strobes drop.
                div             <= div + w_div'(1);
                bus.pixel_en    <= 1'b0;
                bus.line_start  <= 1'b0;
                bus.frame_start <= 1'b0;
            end
        end
    end
endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
- Parametrised LCD/RGB-panel timing generator. One generator covers the 480x272, 480x272 ML6485 and 800x480 panels through parameters instead of one fixed module per panel.
- Derives a pixel-rate strobe from the system clock and produces DE, HSYNC, VSYNC, pixel coordinates, frame/line markers and a frame counter.
- Supports run-time mirroring, latched per frame, and an enable with clean restart.
- Sits between the board top and lab_top: x/y feed the lab, and the sync signals drive the panel pins.

Parameters:
- clk_div, 3, system clocks per pixel (>=1); 27 MHz / 3 = 9 MHz.
- h_active, 480, visible pixels per line.
- h_front, 8, horizontal front porch in pixels.
- h_sync, 4, HSYNC width in pixels.
- h_back, 43, horizontal back porch in pixels.
- v_active, 272, visible lines.
- v_front, 8, vertical front porch in lines.
- v_sync, 4, VSYNC width in lines.
- v_back, 12, vertical back porch in lines.
- hs_pol, 0, HSYNC active level (0 = active-low).
- vs_pol, 0, VSYNC active level.
- w_x, $clog2(h_active), x width.
- w_y, $clog2(v_active), y width.
- w_frame, 16, frame counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run timing; low = idle and restart.
- mirror_x  in  1  horizontal mirror request.
- mirror_y  in  1  vertical mirror request.
- pixel_en  out  1  one-cycle strobe on the first clk of each pixel period.
- de  out  1  data enable, high in the active area.
- hsync  out  1  horizontal sync, polarity hs_pol.
- vsync  out  1  vertical sync, polarity vs_pol.
- x  out  w_x  active-area column.
- y  out  w_y  active-area row.
- line_start  out  1  high with pixel_en at hcnt==0.
- frame_start  out  1  high with pixel_en at hcnt==0, vcnt==0.
- frame_count  out  w_frame  completed-frame counter.

Behaviour:
- Totals: h_total = h_active+h_front+h_sync+h_back (535); v_total = v_active+v_front+v_sync+v_back (296).
- Internal counters: div in 0..clk_div-1, hcnt in 0..h_total-1, vcnt in 0..v_total-1.
- All outputs are registered; each pixel's values are stable for exactly clk_div clk cycles.
- Reset (async, and while enable=0):
  - div=hcnt=vcnt=0.
  - pixel_en=de=line_start=frame_start=0.
  - hsync=~hs_pol, vsync=~vs_pol (inactive).
  - x=y=0; mirror latches=0.
  - frame_count=0 on rst only; enable=0 holds it.
- Start: on the first rising edge with enable=1, outputs present pixel (0,0) with pixel_en=1, line_start=1, frame_start=1.
  - The next pixel follows clk_div cycles later.
  - clk_div=1 gives pixel_en continuously high.
- Advance per pixel:
  - hcnt wraps h_total-1 -> 0, which increments vcnt.
  - vcnt wraps v_total-1 -> 0, which increments frame_count (modulo 2^w_frame, wraps silently).
- de = (hcnt < h_active) && (vcnt < v_active).
- hsync is active for h_active+h_front <= hcnt < h_active+h_front+h_sync, on every line including vertical blanking.
- vsync is active for v_active+v_front <= vcnt < v_active+v_front+v_sync, for whole lines; it changes only at hcnt==0.
- Coordinates:
  - When de=1: x = mirror_x_l ? h_active-1-hcnt : hcnt, and y = mirror_y_l ? v_active-1-vcnt : vcnt.
  - When de=0: x=y=0.
- Mirror inputs are sampled only at frame start (the pixel that presents hcnt=0, vcnt=0). Mid-frame changes take effect the next frame, so there is no tearing.
- enable drop mid-frame: on the next edge, outputs go to the idle values above. Re-enable restarts at (0,0) with frame_start; frame_count is not incremented for the aborted frame.
- rst mid-frame: immediate async idle; restart as at power-up.
- Parameter legality (elaboration check, $error):
  - clk_div>=1; h_sync>=1; v_sync>=1.
  - h_active <= 2^w_x; v_active <= 2^w_y.

Test Plan:
- Defaults, enable=1 from reset:
  - pixel_en period 3 clks.
  - Line = 535 pixels = 1605 clks; frame = 296 lines = 475080 clks.
  - frame_count reaches 2 after 950160 clks from the first frame_start.
- Line 0 check:
  - de high for hcnt 0..479 with x = 0..479.
  - hsync low exactly for hcnt 488..491, high elsewhere.
  - line_start once per 1605 clks.
- Vertical check:
  - vsync low for vcnt 280..283, toggling only when hcnt==0.
  - de=0 for vcnt>=272; y=271 on the last active line.
- Mirror:
  - Assert mirror_x at vcnt=100: x stays unmirrored through that frame.
  - Next frame, hcnt=0 gives x=479 and hcnt=479 gives x=0.
  - mirror_y gives y=271 on vcnt 0.
- Enable/reset mid-frame:
  - Drop enable at vcnt=150: next edge de=0, hsync=vsync=1, x=y=0, frame_count unchanged.
  - Re-enable: frame_start on the first edge.
  - Async rst pulse between clocks: outputs go idle immediately and frame_count=0.
- Parameter sweep clk_div=1, 800x480 (h 800/40/48/88, v 480/13/3/32), hs_pol=vs_pol=1:
  - pixel_en constantly high.
  - h_total 976, v_total 528.
  - hsync high for hcnt 840..887.
